// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART transceiver with TX/RX FIFOs, baud divisor, parity and sticky errors
`timescale 1ns/1ps

module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module uart_fifo_core #(
    parameter int         DATA_BITS  = 8,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] DIV_RESET  = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] address,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    input  logic       we,
    input  logic       re,
    output logic       tx,
    input  logic       rx,
    output logic       irq
);
    localparam int DW = DATA_BITS;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0] div_q;
    logic [5:0] ctrl_q;
    logic       par_err_q, frame_err_q, overrun_q;
    logic       tx_en, rx_en, par_en, par_odd, irq_rx_en, irq_txe_en;
    logic       wr_div, wr_ctrl, wr_data, wr_stat, rd_data;
    logic [7:0] status, rd_mux;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [DW-1:0] tx_head, rx_head;

    assign {irq_txe_en, irq_rx_en, par_odd, par_en, rx_en, tx_en} = ctrl_q;
    assign wr_div  = we && (address == 2'd0);
    assign wr_ctrl = we && (address == 2'd1);
    assign wr_data = we && (address == 2'd2);
    assign wr_stat = we && (address == 2'd3);
    assign rd_data = re && (address == 2'd2);

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_next;
    logic [11:0]   tx_cnt;
    logic [2:0]    tx_idx;
    logic [DW-1:0] tx_shift;
    logic [7:0]    tx_div;
    logic          tx_par_en, tx_par_bit, tx_pop, tx_bit, tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_cnt == {tx_div, 4'hF});
    assign tx_busy    = (tx_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_bit  = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (tx_en && !tx_empty) begin
                    tx_next = S_START;
                    tx_pop  = 1'b1;
                end
            end
            S_START: begin
                tx_bit = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_bit = tx_shift[0];
                if (tx_bit_end && tx_idx == 3'(DW-1)) tx_next = tx_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_bit = tx_par_bit;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP: begin
                if (tx_bit_end) tx_next = S_IDLE;
            end
            default: tx_next = S_IDLE;
        endcase
    end

    // Pin is the state's bit delayed one clock, so tx falls the cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx         <= 1'b1;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            tx_div     <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
        end else begin
            tx <= tx_bit;
            if (tx_pop) begin
                tx_cnt     <= '0;
                tx_idx     <= '0;
                tx_shift   <= tx_head;
                tx_div     <= div_q;
                tx_par_en  <= par_en;
                tx_par_bit <= ^tx_head ^ par_odd;
            end else if (tx_state != S_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 12'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    state_t        rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_prev, rx_begin;
    logic [11:0]   rx_cnt;
    logic [2:0]    rx_idx;
    logic [DW-1:0] rx_shift, rx_word_q;
    logic [7:0]    rx_div;
    logic          rx_par_en, rx_par_odd, rx_push_q;
    logic          rx_half_end, rx_bit_end, rx_par_set, rx_stop_smp, rx_over_set;

    assign rx_half_end = (rx_cnt == {1'b0, rx_div, 3'h7});
    assign rx_bit_end  = (rx_cnt == {rx_div, 4'hF});
    assign rx_par_set  = rx_en && (rx_state == S_PARITY) && rx_bit_end
                         && (rx_s2 != (^rx_shift ^ rx_par_odd));
    assign rx_stop_smp = rx_en && (rx_state == S_STOP) && rx_bit_end;
    assign rx_over_set = rx_push_q && rx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next  = rx_state;
        rx_begin = 1'b0;
        if (!rx_en) begin
            rx_next = S_IDLE;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_next  = S_START;
                        rx_begin = 1'b1;
                    end
                end
                S_START:  if (rx_half_end) rx_next = rx_s2 ? S_IDLE : S_DATA;
                S_DATA:   if (rx_bit_end && rx_idx == 3'(DW-1)) rx_next = rx_par_en ? S_PARITY : S_STOP;
                S_PARITY: if (rx_bit_end) rx_next = S_STOP;
                S_STOP:   if (rx_bit_end) rx_next = S_IDLE;
                default:  rx_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_div     <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_word_q  <= '0;
        end else begin
            rx_s1     <= rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_push_q <= rx_stop_smp && rx_s2;
            if (rx_stop_smp) rx_word_q <= rx_shift;
            if (rx_begin) begin
                rx_cnt     <= '0;
                rx_idx     <= '0;
                rx_div     <= div_q;
                rx_par_en  <= par_en;
                rx_par_odd <= par_odd;
            end else if (rx_state == S_START) begin
                rx_cnt <= rx_half_end ? 12'd0 : rx_cnt + 12'd1;
            end else if (rx_state != S_IDLE) begin
                if (rx_bit_end) begin
                    rx_cnt <= '0;
                    if (rx_state == S_DATA) begin
                        rx_shift <= {rx_s2, rx_shift[DW-1:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 12'd1;
                end
            end
        end
    end

    // ---------------- FIFOs and register port ----------------
    uart_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(wr_data), .push_data(write_data[DW-1:0]),
        .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_q), .push_data(rx_word_q),
        .pop(rd_data), .pop_data(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign status = {tx_busy, overrun_q, frame_err_q, par_err_q, rx_empty, rx_full, tx_empty, tx_full};
    assign irq    = (irq_rx_en && !rx_empty) || (irq_txe_en && tx_empty && !tx_busy);

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = div_q;
            2'd1:    rd_mux = {2'b00, ctrl_q};
            2'd2:    rd_mux = rx_empty ? 8'h00 : 8'(rx_head);
            default: rd_mux = status;
        endcase
    end

    // Error flags: a new event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= DIV_RESET;
            ctrl_q      <= '0;
            read_data   <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_div)  div_q  <= write_data;
            if (wr_ctrl) ctrl_q <= write_data[5:0];
            if (re)      read_data <= rd_mux;
            if (wr_stat && write_data[4]) par_err_q   <= 1'b0;
            if (wr_stat && write_data[5]) frame_err_q <= 1'b0;
            if (wr_stat && write_data[6]) overrun_q   <= 1'b0;
            if (rx_par_set)                par_err_q   <= 1'b1;
            if (rx_stop_smp && !rx_s2)     frame_err_q <= 1'b1;
            if (rx_over_set)               overrun_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - scoreboard bench for uart_fifo_core with TX frame decoder and RX model
`timescale 1ns/1ps

module tb_uart_fifo_core;
    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] address = '0;
    logic [7:0] write_data = '0, read_data;
    logic       we = 1'b0, re = 1'b0;
    logic       tx, rx, irq;
    logic       loop_en = 1'b0, rx_drv = 1'b1;

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_RESET(8'd0)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .read_data(read_data), .we(we), .re(re), .tx(tx), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    logic [7:0] rd_exp[$], tx_exp[$], rx_model[$];
    logic       m_par = 1'b0, m_frame = 1'b0, m_over = 1'b0;
    logic       m_par_en = 1'b0, m_par_odd = 1'b0, mon_en = 1'b0;
    int         m_div = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic void rx_accept(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        if (bad_par) m_par = 1'b1;
        if (bad_stop)                  m_frame = 1'b1;
        else if (rx_model.size() == 8) m_over = 1'b1;
        else                           rx_model.push_back(d);
    endfunction

    function automatic logic [7:0] exp_status(input int tx_cnt);
        return {1'b0, m_over, m_frame, m_par, rx_model.size() == 0, rx_model.size() == 8,
                tx_cnt == 0, tx_cnt == 8};
    endfunction

    // Read monitor: every re strobe yields one registered read_data value to compare.
    always @(posedge clk) begin
        if (re) begin
            @(negedge clk);
            if (rd_exp.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL read_unexpected: got %02h expected none", read_data);
            end else begin
                chk("read_data", read_data, rd_exp.pop_front());
            end
        end
    end

    // TX monitor: decode frames off the pin at mid-bit and score them against tx_exp.
    initial begin
        logic       prev;
        logic [7:0] w;
        int         p;
        logic       pe, po;
        prev = 1'b1;
        w = '0;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx) begin
                p = 16 * (m_div + 1); pe = m_par_en; po = m_par_odd;
                repeat (p / 2) @(negedge clk);
                chk("tx_start", {7'b0, tx}, 8'h00);
                for (int k = 0; k < 8; k++) begin
                    repeat (p) @(negedge clk);
                    w[k] = tx;
                end
                if (pe) begin
                    repeat (p) @(negedge clk);
                    chk("tx_parity", {7'b0, tx}, {7'b0, ^w ^ po});
                end
                repeat (p) @(negedge clk);
                chk("tx_stop", {7'b0, tx}, 8'h01);
                if (tx_exp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tx_unexpected_frame: got %02h expected none", w);
                end else begin
                    chk("tx_word", w, tx_exp.pop_front());
                end
            end
            prev = tx;
        end
    end

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); address = a; write_data = d; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e);
        @(negedge clk); address = a; re = 1'b1; rd_exp.push_back(e);
        @(negedge clk); re = 1'b0;
    endtask

    task automatic rd_status(input int tx_cnt);
        rd(2'd3, exp_status(tx_cnt));
    endtask

    task automatic rd_word();
        logic [7:0] e;
        e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        rd(2'd2, e);
    endtask

    task automatic send_tx(input logic [7:0] d);
        tx_exp.push_back(d);
        if (loop_en) rx_accept(d, 1'b0, 1'b0);
        wr(2'd2, d);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pe, input logic po,
                           input logic bad_par, input logic bad_stop);
        int p;
        p = 16 * (m_div + 1);
        @(negedge clk);
        rx_drv = 1'b0; repeat (p) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = d[k]; repeat (p) @(negedge clk);
        end
        if (pe) begin
            rx_drv = ^d ^ po ^ bad_par; repeat (p) @(negedge clk);
        end
        rx_drv = !bad_stop; repeat (p) @(negedge clk);
        rx_drv = 1'b1; repeat (p) @(negedge clk);
        rx_accept(d, bad_par, bad_stop);
    endtask

    task automatic wait_drain(input int extra);
        for (int i = 0; i < 20000 && tx_exp.size() != 0; i++) @(negedge clk);
        chk("tx_drain_done", 8'(tx_exp.size()), 8'h00);
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a frame with queued words
        wr(2'd0, 8'd3); rd(2'd0, 8'd3);
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h00); wr(2'd2, 8'hAA); wr(2'd2, 8'h0F);
        repeat (100) @(negedge clk);
        chk("midframe_tx", {7'b0, tx}, 8'h00);
        #2 rst = 1'b1;
        #1 chk("rst_tx", {7'b0, tx}, 8'h01);
        chk("rst_read_data", read_data, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        @(negedge clk); rst = 1'b0;
        mon_en = 1'b1;
        rd(2'd0, 8'h00); rd(2'd1, 8'h00); rd_status(0);
        rd(2'd2, 8'h00); rd(2'd2, 8'h00); rd_status(0);
        wr(2'd1, 8'h01);
        repeat (40) @(negedge clk);
        chk("flushed_tx_idle", {7'b0, tx}, 8'h01);
        rd_status(0);

        wr(2'd1, 8'h20);
        chk("irq_txe", {7'b0, irq}, 8'h01);
        wr(2'd1, 8'h01);
        chk("irq_off", {7'b0, irq}, 8'h00);

        // Exact TX timing at DIV=0, 0x69
        m_div = 0; m_par_en = 1'b0;
        d = 8'h69;
        tx_exp.push_back(d);
        wr(2'd2, d);
        @(negedge clk); chk("tx_n1", {7'b0, tx}, 8'h01);
        @(negedge clk); chk("tx_n2", {7'b0, tx}, 8'h00);
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? 8 : 16) @(negedge clk);
            chk("tx_bit", {7'b0, tx}, (k == 0) ? 8'h00 : (k == 9) ? 8'h01 : {7'b0, d[k-1]});
        end
        repeat (6) @(negedge clk);
        address = 2'd3; re = 1'b1; rd_exp.push_back(8'h8A);
        @(negedge clk); rd_exp.push_back(8'h0A);
        @(negedge clk); re = 1'b0;
        wait_drain(4);

        // Loopback, odd parity
        loop_en = 1'b1; m_div = $urandom_range(0, 1); m_par_en = 1'b1; m_par_odd = 1'b1;
        wr(2'd0, 8'(m_div)); wr(2'd1, 8'h0F);
        send_tx(8'hB4);
        repeat (3) send_tx(8'($urandom));
        wait_drain(32 * (m_div + 1));
        repeat (4) rd_word();
        rd_status(0);

        // Wrong parity on rx: flag set, word kept
        loop_en = 1'b0; wr(2'd1, 8'h0E);
        send_rx(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
        send_rx(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        rd_status(0);
        rd_word(); rd_word();
        wr(2'd3, 8'h10); m_par = 1'b0;
        rd_status(0);

        // TX FIFO overflow with tx disabled
        wr(2'd1, 8'h00); m_div = 0; wr(2'd0, 8'h00); m_par_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            if (i < 8) tx_exp.push_back(d);
            wr(2'd2, d);
        end
        rd_status(8);
        wr(2'd1, 8'h01);
        wait_drain(40);
        rd_status(0);

        // RX overrun: nine loopback frames, no reads
        loop_en = 1'b1; m_div = $urandom_range(0, 1);
        wr(2'd0, 8'(m_div)); wr(2'd1, 8'h03);
        repeat (9) send_tx(8'($urandom));
        wait_drain(48 * (m_div + 1));
        rd_status(0);
        wr(2'd1, 8'h13);
        chk("irq_rx", {7'b0, irq}, 8'h01);
        repeat (8) rd_word();
        chk("irq_rx_empty", {7'b0, irq}, 8'h00);
        rd_status(0);
        wr(2'd3, 8'h40); m_over = 1'b0;
        rd_status(0);

        // Framing error: word discarded
        loop_en = 1'b0; wr(2'd1, 8'h02);
        send_rx(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        rd_status(0);
        wr(2'd3, 8'h20); m_frame = 1'b0;
        rd_status(0);

        // Short glitch at DIV=1 must not start a frame
        m_div = 1; wr(2'd0, 8'd1);
        @(negedge clk); rx_drv = 1'b0;
        repeat (4) @(negedge clk); rx_drv = 1'b1;
        repeat (80) @(negedge clk);
        rd_status(0);
        send_rx(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        rd_word(); rd_status(0);

        // Random loopback burst with random framing
        loop_en = 1'b1; m_div = $urandom_range(0, 2);
        m_par_en = 1'($urandom_range(0, 1)); m_par_odd = 1'($urandom_range(0, 1));
        wr(2'd0, 8'(m_div)); wr(2'd1, {4'b0000, m_par_odd, m_par_en, 2'b11});
        repeat (5) send_tx(8'($urandom));
        wait_drain(48 * (m_div + 1));
        repeat (5) rd_word();
        rd_status(0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised UART transceiver with TX/RX FIFOs, programmable baud divisor, optional parity and sticky error flags, behind the same 2-bit address / `we` / `re` register port the USB-to-UART bridge already uses. Sits between the SRAM-fed host-side bus and the `tx`/`rx` pins, and replaces the single-buffered UART core. It adds buffering, a status register and an interrupt line.

## Interface
- `DATA_BITS`, 8: character length, legal 5..8; unused upper bits of `write_data` ignored, of `read_data` driven 0.
- `FIFO_DEPTH`, 8: entries per FIFO, power of two, ≥2.
- `DIV_RESET`, 8'd0: reset value of the divisor register.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address`  in  2  register select.
- `write_data`  in  8  write bus.
- `read_data`  out  8  registered read bus.
- `we`  in  1  write strobe, one access per cycle high.
- `re`  in  1  read strobe, one access per cycle high.
- `tx`  out  1  serial out, idle high.
- `rx`  in  1  serial in, asynchronous, idle high.
- `irq`  out  1  level interrupt.

## Operation
- Register map:
  - addr 0 DIV (R/W): bit period = 16*(DIV+1) clk.
  - addr 1 CTRL (R/W): b0 tx_en, b1 rx_en, b2 par_en, b3 par_odd, b4 irq_rx_en, b5 irq_txe_en; reset 0.
  - addr 2 DATA: write pushes TX FIFO; read pops RX FIFO.
  - addr 3 STATUS (R): b0 tx_full, b1 tx_empty, b2 rx_full, b3 rx_empty, b4 par_err, b5 frame_err, b6 overrun, b7 tx_busy. Write-1-to-clear on b4..b6.
- Boundary rules:
  - Push to a full TX FIFO is dropped silently.
  - Pop of an empty RX FIFO returns 0 and leaves the pointers unchanged.
  - Simultaneous push and pop on one FIFO in the same cycle both take effect; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty derived from a count of width log2(FIFO_DEPTH)+1.
- TX FSM, states IDLE→START→DATA→PARITY (skipped if !par_en)→STOP→IDLE:
  - Leaves IDLE when tx_en && !tx_empty, popping one word.
  - Frame: start 0, DATA_BITS LSB first, parity if enabled, one stop 1. Each bit 16*(DIV+1) clk, from a prescaler restarted at frame start.
  - Parity: XOR of data bits; even when par_odd=0, inverted when par_odd=1.
  - Clearing tx_en mid-frame finishes the current frame, then holds IDLE.
  - DIV and CTRL are sampled at frame start only.
- RX FSM, states IDLE→START→DATA→PARITY→STOP:
  - `rx` passes through a 2-flop synchroniser.
  - Falling edge in IDLE with rx_en starts the frame. Start bit is re-checked at mid-bit (8*(DIV+1) clk); if high, return to IDLE (glitch).
  - Subsequent bits are sampled every 16*(DIV+1) clk at mid-bit.
  - Parity mismatch sets par_err; the word is still stored.
  - Stop bit sampled 0 sets frame_err; the word is discarded.
  - Completion with RX FIFO full sets overrun; the word is dropped.
  - Clearing rx_en aborts at once; the partial word is discarded.
- irq = (irq_rx_en && !rx_empty) || (irq_txe_en && tx_empty && !tx_busy).

## Timing
- Reset values: tx=1, read_data=0, irq=0, both FIFOs empty, STATUS=8'h0A, DIV=DIV_RESET, CTRL=0. Reset asserted mid-frame forces tx=1 immediately and flushes both FIFOs.
- Write: `we` at edge N updates the register or FIFO at N. For a DATA write while tx_en and idle, the pop happens at N+1 and `tx` falls at N+2.
- Read: `re` at edge N puts the data on `read_data` after edge N; it is held until the next `re`. The pop takes effect at N.
- STATUS read reflects state before any same-cycle update.
- RX: a word is pushed one cycle after the stop-bit sample. rx_empty and irq change on that same edge.
- tx_busy is high from the pop cycle through the last stop-bit clock.

## Test plan
- Reset mid-frame, then check all registers → STATUS=8'h0A, tx=1, DIV=DIV_RESET, read_data=0.
- DIV=0, CTRL=8'h01, write 8'h69 → tx low at N+2; bits 1,0,0,1,0,1,1,0 LSB first, 16 clk each; stop high; tx_busy clears at clk 160.
- `tx` looped to `rx`, CTRL=8'h0F (odd parity), write 8'hB4 → RX read returns 8'hB4, par_err=0, frame_err=0. Same test with rx parity forced wrong → par_err=1, word still stored.
- Write FIFO_DEPTH+2 words with tx_en=0 → tx_full=1 after 8 writes, extra 2 writes dropped; then tx_en=1 → exactly 8 frames sent, tx_empty=1.
- Loopback 9 frames with no reads → overrun=1, 8 words readable in order; write 8'h40 to addr 3 → overrun=0.
- Stop bit driven 0 on rx → frame_err=1, rx_empty stays 1. A 4-clk low glitch at DIV=1 → no frame started.
